// File: rtl/traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : traffic_phase_scheduler
//  Purpose  : Two-road intersection phase sequencer. Steps G1 -> Y1 -> G2 ->
//             Y2 (optionally with all-red clearance after each yellow) on a
//             1 Hz tick enable, accepts new green/yellow durations through a
//             valid/ack shadow register applied at each G1 entry, and
//             shortens the active green when a pedestrian request is pending.
//  Option   : `define TRAFFIC_ALL_RED_CLEAR_EN inserts AR1/AR2 phases
//             (both roads red for AR_TIME ticks) after each yellow.
//  Ports    : clk        - system clock
//             rst        - asynchronous, active-low reset
//             tick       - one-clk-wide 1 Hz timing enable
//             hold       - freeze timer and phase while high
//             cfg_valid  - new durations present on cfg_g / cfg_y
//             cfg_g/y    - requested green / yellow durations (ticks)
//             cfg_ack    - one-cycle pulse: cfg values captured
//             ped_req    - bit i requests a stop of road i+1
//             ped_pend   - latched, not yet served pedestrian requests
//             T1, T2     - road lamps {R,Y,G}, one-hot, active high
//             remain     - ticks left in the current phase
//             phase      - state encoding G1=0 Y1=1 G2=2 Y2=3 AR1=4 AR2=5
//  Revision : 1.0 - initial release
// ============================================================================
module traffic_phase_scheduler #(
    parameter int W         = 4,
    parameter int G_RST     = 5,
    parameter int Y_RST     = 1,
    parameter int MIN_GREEN = 2,
    parameter int AR_TIME   = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick,
    input  logic         hold,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_g,
    input  logic [W-1:0] cfg_y,
    output logic         cfg_ack,
    input  logic [1:0]   ped_req,
    output logic [1:0]   ped_pend,
    output logic [2:0]   T1,
    output logic [2:0]   T2,
    output logic [W-1:0] remain,
    output logic [2:0]   phase
);

    localparam logic [2:0] c_G1  = 3'd0;
    localparam logic [2:0] c_Y1  = 3'd1;
    localparam logic [2:0] c_G2  = 3'd2;
    localparam logic [2:0] c_Y2  = 3'd3;
    localparam logic [2:0] c_AR1 = 3'd4;
    localparam logic [2:0] c_AR2 = 3'd5;

    localparam logic [W-1:0] c_G_RST = W'(G_RST);
    localparam logic [W-1:0] c_Y_RST = W'(Y_RST);
    localparam logic [W-1:0] c_MIN   = W'(MIN_GREEN);
    localparam logic [W-1:0] c_AR    = W'(AR_TIME);
    localparam logic [W-1:0] c_ONE   = W'(1);

    // A zero duration would make the phase vanish; run it for one tick instead.
    function automatic logic [W-1:0] clamp_dur(input logic [W-1:0] d);
        return (d == '0) ? c_ONE : d;
    endfunction

    function automatic logic [2:0] next_phase(input logic [2:0] s);
        case (s)
            c_G1:    return c_Y1;
`ifdef TRAFFIC_ALL_RED_CLEAR_EN
            c_Y1:    return c_AR1;
            c_Y2:    return c_AR2;
`else
            c_Y1:    return c_G2;
            c_Y2:    return c_G1;
`endif
            c_AR1:   return c_G2;
            c_G2:    return c_Y2;
            c_AR2:   return c_G1;
            default: return c_G1;
        endcase
    endfunction

    // {T1, T2}
    function automatic logic [5:0] lamps_of(input logic [2:0] s);
        case (s)
            c_G1:    return 6'b001_100;
            c_Y1:    return 6'b010_100;
            c_G2:    return 6'b100_001;
            c_Y2:    return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    logic [2:0]   state_q,  state_d;
    logic [W-1:0] timer_q,  timer_d;
    logic [W-1:0] g_q,      g_d;
    logic [W-1:0] y_q,      y_d;
    logic [W-1:0] sh_g_q,   sh_g_d;
    logic [W-1:0] sh_y_q,   sh_y_d;
    logic         sh_full_q, sh_full_d;
    logic [1:0]   ped_q,    ped_d;
    logic [5:0]   lamps_q,  lamps_d;
    logic         ack_q;

    logic         w_run;
    logic         w_adv;
    logic         w_enter_g1;
    logic         w_trunc;
    logic [2:0]   w_nxt;
    logic [1:0]   w_ped;
    logic [1:0]   w_clr;

    always_comb begin
        w_run      = tick & ~hold;
        w_adv      = w_run & (timer_q == c_ONE);
        w_nxt      = next_phase(state_q);
        w_enter_g1 = w_adv & (w_nxt == c_G1);
        // Same-cycle requests count, so truncation lands one cycle after the
        // request pulse rather than two.
        w_ped      = ped_q | ped_req;
        w_trunc    = ~hold & (timer_q > c_MIN) &
                     (((state_q == c_G1) & w_ped[0]) |
                      ((state_q == c_G2) & w_ped[1]));

        state_d = w_adv ? w_nxt : state_q;

        // Shadow becomes active only at G1 entry; g_d is then used for the
        // very G1 load below.
        g_d = g_q;
        y_d = y_q;
        if (w_enter_g1 && sh_full_q) begin
            g_d = sh_g_q;
            y_d = sh_y_q;
        end

        // A capture on the G1-entry edge refills the shadow after the copy.
        sh_g_d    = sh_g_q;
        sh_y_d    = sh_y_q;
        sh_full_d = sh_full_q;
        if (cfg_valid) begin
            sh_g_d    = cfg_g;
            sh_y_d    = cfg_y;
            sh_full_d = 1'b1;
        end else if (w_enter_g1) begin
            sh_full_d = 1'b0;
        end

        timer_d = timer_q;
        if (w_adv) begin
            case (w_nxt)
                c_G1, c_G2: timer_d = clamp_dur(g_d);
                c_Y1, c_Y2: timer_d = clamp_dur(y_d);
                default:    timer_d = clamp_dur(c_AR);
            endcase
        end else if (w_trunc) begin
            timer_d = c_MIN;
        end else if (w_run) begin
            timer_d = timer_q - c_ONE;
        end

        w_clr[0] = w_adv & (w_nxt == c_Y1);
        w_clr[1] = w_adv & (w_nxt == c_Y2);
        ped_d    = (ped_q & ~w_clr) | ped_req;

        lamps_d  = lamps_of(state_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= c_G1;
            timer_q   <= clamp_dur(c_G_RST);
            g_q       <= c_G_RST;
            y_q       <= c_Y_RST;
            sh_g_q    <= '0;
            sh_y_q    <= '0;
            sh_full_q <= 1'b0;
            ped_q     <= 2'b00;
            lamps_q   <= 6'b001_100;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            g_q       <= g_d;
            y_q       <= y_d;
            sh_g_q    <= sh_g_d;
            sh_y_q    <= sh_y_d;
            sh_full_q <= sh_full_d;
            ped_q     <= ped_d;
            lamps_q   <= lamps_d;
            ack_q     <= cfg_valid;
        end
    end

    assign T1       = lamps_q[5:3];
    assign T2       = lamps_q[2:0];
    assign remain   = timer_q;
    assign phase    = state_q;
    assign ped_pend = ped_q;
    assign cfg_ack  = ack_q;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_traffic_phase_scheduler
//  Purpose  : Directed, self-checking bench for traffic_phase_scheduler in
//             its default build (no all-red clearance). Inputs change 1 time
//             unit after the rising edge; outputs are checked there too.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_scheduler;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         tick = 1'b0;
    logic         hold = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_g = '0;
    logic [W-1:0] cfg_y = '0;
    logic         cfg_ack;
    logic [1:0]   ped_req = 2'b00;
    logic [1:0]   ped_pend;
    logic [2:0]   T1;
    logic [2:0]   T2;
    logic [W-1:0] remain;
    logic [2:0]   phase;

    int n_checks = 0;
    int n_errors = 0;

    traffic_phase_scheduler #(
        .W(W), .G_RST(5), .Y_RST(1), .MIN_GREEN(2), .AR_TIME(1)
    ) dut (
        .clk(clk), .rst(rst), .tick(tick), .hold(hold),
        .cfg_valid(cfg_valid), .cfg_g(cfg_g), .cfg_y(cfg_y), .cfg_ack(cfg_ack),
        .ped_req(ped_req), .ped_pend(ped_pend),
        .T1(T1), .T2(T2), .remain(remain), .phase(phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Independent lamp table {T1,T2} per phase code.
    function automatic logic [5:0] exp_lamps(input int ph);
        case (ph)
            0:       return 6'b001_100;
            1:       return 6'b010_100;
            2:       return 6'b100_001;
            3:       return 6'b100_010;
            default: return 6'b100_100;
        endcase
    endfunction

    task automatic chk_state(input string tag, input int ph, input int rem);
        chk({tag, "_phase"},  16'(phase),    16'(ph));
        chk({tag, "_remain"}, 16'(remain),   16'(rem));
        chk({tag, "_lamps"},  16'({T1, T2}), 16'(exp_lamps(ph)));
    endtask

    task automatic clock_once();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_chk(input string tag, input int ph, input int rem);
        tick = 1'b1;
        clock_once();
        tick = 1'b0;
        chk_state(tag, ph, rem);
    endtask

    int seq_ph  [16] = '{0,0,0,0,1,2,2,2,2,2,3,0,0,0,0,0};
    int seq_rem [16] = '{4,3,2,1,1,5,4,3,2,1,1,5,4,3,2,1};

    initial begin
        // ---------------- reset defaults ----------------
        repeat (2) @(posedge clk);
        #1;
        chk_state("rst", 0, 5);
        chk("rst_ped", 16'(ped_pend), 16'd0);
        chk("rst_ack", 16'(cfg_ack), 16'd0);
        rst = 1'b1;

        // ---------------- one full cycle on defaults ----------------
        for (int i = 0; i < 16; i++)
            tick_chk($sformatf("seq%0d", i), seq_ph[i], seq_rem[i]);
        tick_chk("seq16", 1, 1);
        tick_chk("seq17", 2, 5);
        tick_chk("seq18", 2, 4);

        // ---------------- configuration mid-G2 ----------------
        cfg_valid = 1'b1; cfg_g = 4'd3; cfg_y = 4'd2;
        clock_once();
        cfg_valid = 1'b0;
        chk("cfg_ack_hi", 16'(cfg_ack), 16'd1);
        chk("cfg_hold_rem", 16'(remain), 16'd4);
        clock_once();
        chk("cfg_ack_lo", 16'(cfg_ack), 16'd0);
        tick_chk("cfg_g2a", 2, 3);
        tick_chk("cfg_g2b", 2, 2);
        tick_chk("cfg_g2c", 2, 1);
        tick_chk("cfg_y2", 3, 1);
        tick_chk("cfg_g1a", 0, 3);
        tick_chk("cfg_g1b", 0, 2);
        tick_chk("cfg_g1c", 0, 1);
        tick_chk("cfg_y1a", 1, 2);
        tick_chk("cfg_y1b", 1, 1);
        tick_chk("cfg_g2n", 2, 3);

        // ---------------- asynchronous reset mid-phase ----------------
        rst = 1'b0;
        #2;
        chk_state("arst", 0, 5);
        clock_once();
        rst = 1'b1;

        // ---------------- pedestrian request road 1 ----------------
        ped_req = 2'b01;
        clock_once();
        ped_req = 2'b00;
        chk_state("ped0_trunc", 0, 2);
        chk("ped0_pend", 16'(ped_pend), 16'b01);
        tick_chk("ped0_g1", 0, 1);
        tick_chk("ped0_y1", 1, 1);
        chk("ped0_clr", 16'(ped_pend), 16'b00);

        // ---------------- pedestrian request road 2 during G1 ----------------
        tick_chk("p1_g2a", 2, 5);
        tick_chk("p1_g2b", 2, 4);
        tick_chk("p1_g2c", 2, 3);
        tick_chk("p1_g2d", 2, 2);
        tick_chk("p1_g2e", 2, 1);
        tick_chk("p1_y2", 3, 1);
        tick_chk("p1_g1", 0, 5);
        ped_req = 2'b10;
        clock_once();
        ped_req = 2'b00;
        chk("ped1_no_trunc", 16'(remain), 16'd5);
        chk("ped1_pend", 16'(ped_pend), 16'b10);
        tick_chk("ped1_g1a", 0, 4);
        tick_chk("ped1_g1b", 0, 3);
        tick_chk("ped1_g1c", 0, 2);
        tick_chk("ped1_g1d", 0, 1);
        tick_chk("ped1_y1", 1, 1);
        tick_chk("ped1_g2load", 2, 5);
        clock_once();
        chk_state("ped1_trunc", 2, 2);
        tick_chk("ped1_g2e", 2, 1);
        tick_chk("ped1_y2", 3, 1);
        chk("ped1_clr", 16'(ped_pend), 16'b00);

        // ---------------- hold ----------------
        tick_chk("hold_g1", 0, 5);
        tick_chk("hold_pre", 0, 4);
        hold = 1'b1;
        tick_chk("hold_a", 0, 4);
        tick_chk("hold_b", 0, 4);
        tick_chk("hold_c", 0, 4);
        hold = 1'b0;
        tick_chk("hold_rel", 0, 3);

        // ---------------- zero green duration ----------------
        cfg_valid = 1'b1; cfg_g = 4'd0; cfg_y = 4'd1;
        clock_once();
        cfg_valid = 1'b0;
        chk("z_ack", 16'(cfg_ack), 16'd1);
        tick_chk("z_g1a", 0, 2);
        tick_chk("z_g1b", 0, 1);
        tick_chk("z_y1", 1, 1);
        tick_chk("z_g2a", 2, 5);
        tick_chk("z_g2b", 2, 4);
        tick_chk("z_g2c", 2, 3);
        tick_chk("z_g2d", 2, 2);
        tick_chk("z_g2e", 2, 1);
        tick_chk("z_y2", 3, 1);
        tick_chk("z_g1one", 0, 1);
        tick_chk("z_y1n", 1, 1);
        tick_chk("z_g2one", 2, 1);
        tick_chk("z_y2n", 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/traffic_phase_scheduler.md
Name: traffic_phase_scheduler

Overview:
- Sequences a two-road intersection through its green, yellow and all-red phases.
- Counts a 1-tick-per-second enable from the shared clock divider and drives both lamp groups plus a remaining-time display.
- Phase durations come from the configuration/button logic through a valid/ack handshake, taking effect only at cycle boundaries.
- Pedestrian requests shorten the active green to a minimum.

Parameters:
- W, 4, width of duration, remain and timer fields
- G_RST, 5, green duration after reset, in ticks
- Y_RST, 1, yellow duration after reset, in ticks
- MIN_GREEN, 2, green length remaining after a pedestrian truncation, in ticks
- AR_TIME, 1, all-red clearance duration in ticks (used only with ALL_RED_CLEAR_EN)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- tick  in  1  one-clk-wide timing enable, 1 Hz
- hold  in  1  freeze the timer and phase while high
- cfg_valid  in  1  new durations present on cfg_g/cfg_y
- cfg_g  in  W  requested green duration
- cfg_y  in  W  requested yellow duration
- cfg_ack  out  1  one-cycle pulse: cfg values captured
- ped_req  in  2  bit i = pedestrian request to stop road i+1, pulse or level
- ped_pend  out  2  latched pedestrian requests not yet served
- T1  out  3  road 1 lamps {R,Y,G}, one-hot, active high
- T2  out  3  road 2 lamps {R,Y,G}, one-hot, active high
- remain  out  W  ticks left in the current phase
- phase  out  3  current state encoding, for debug and LEDs

Behaviour:
- Reset (rst=0, async):
  - state=G1; active g=G_RST, y=Y_RST; shadow registers cleared and marked empty.
  - timer=G_RST; T1=001; T2=100; remain=G_RST; ped_pend=00; cfg_ack=0.
- States and lamps:
  - G1: T1=001, T2=100
  - Y1: T1=010, T2=100
  - G2: T1=100, T2=001
  - Y2: T1=100, T2=010
  - AR1, AR2 (optional): T1=T2=100
- Sequence: G1->Y1->[AR1]->G2->Y2->[AR2]->G1.
- Timer:
  - Each clk with tick=1 and hold=0: if timer==1, advance state and load the new phase duration; else decrement.
  - Phase durations: G states use g, Y states use y, AR states use AR_TIME.
  - A duration of 0 is loaded as 1, so no phase is skipped.
  - remain equals timer, registered; all lamp outputs are registered.
  - tick arriving while hold=1 is discarded, not queued.
- Configuration handshake:
  - cfg_valid=1 captures cfg_g/cfg_y into the shadow and pulses cfg_ack on the next cycle.
  - A newer cfg_valid overwrites the shadow (last writer wins).
  - Shadow is copied to the active g/y on the same edge the FSM enters G1; the new g is used for that G1's load.
  - cfg_valid in the same cycle as G1 entry is captured but applies at the following G1 entry.
- Pedestrian requests:
  - ped_req[i] sets ped_pend[i].
  - ped_pend[0] clears on entry to Y1; ped_pend[1] clears on entry to Y2.
  - A request arriving in the same cycle as the clear remains set.
  - Truncation, while in G1 with ped_pend[0]=1 (G2 with ped_pend[1]=1) and timer>MIN_GREEN: timer<=MIN_GREEN on that cycle.
  - Truncation overrides a coincident tick decrement; it happens once per green phase, since timer is then no longer greater than MIN_GREEN.
  - Requests during the other road's green or during yellow wait for the next eligible green.
- Reset mid-phase: returns immediately to the G1 reset state; a pending shadow is discarded.

Optional Feature:
- Macro: TRAFFIC_ALL_RED_CLEAR_EN.
- Defined: AR1/AR2 are inserted after each yellow, lasting AR_TIME ticks (0 is treated as 1) with both roads red; phase encodes AR1=4, AR2=5.
- Undefined: Y1->G2 and Y2->G1 directly; states 4/5 are unreachable and the phase output never shows them.
- Encoding: G1=0, Y1=1, G2=2, Y2=3.

Test Plan:
- Reset defaults, 16 ticks, feature off -> G1 for 5 ticks (remain 5,4,3,2,1), Y1 1, G2 5, Y2 1, then G1 again; lamps match the state table.
- cfg_valid g=3,y=2 mid-G2 -> cfg_ack one cycle later; Y2 still 1 tick; next G1 remain=3, Y1 lasts 2.
- ped_req[0] pulse in G1 at remain=5 -> remain=2 next cycle and ped_pend=01; Y1 after 2 ticks; ped_pend=00 on Y1 entry.
- ped_req[1] during G1 -> no truncation in G1; G2 loads 5 then drops to 2 the next cycle; cleared at Y2.
- hold=1 for 3 ticks at remain=4 -> remain stays 4 and lamps unchanged; resumes on release. cfg_g=0 -> green lasts 1 tick.
- TRAFFIC_ALL_RED_CLEAR_EN defined, AR_TIME=1 -> T1=T2=100 for 1 tick between Y1 and G2; rst low asynchronously mid-AR1 -> G1, T1=001, remain=5.
